// File: rtl/order_timer_pkg.sv
// Shared types and constants for the round timer.
//   state_e    - round controller states
//   TIME_W     - width of the seconds counter shown on the score display
//   NUM_ORDERS - number of orders tracked per round
//   sat_sub    - subtraction that clamps at zero
package order_timer_pkg;

    localparam int unsigned TIME_W     = 16;
    localparam int unsigned NUM_ORDERS = 3;

    typedef enum logic [1:0] {
        StIdle,
        StRunning,
        StPaused,
        StDone
    } state_e;

    function automatic logic [TIME_W-1:0] sat_sub(input logic [TIME_W-1:0] a,
                                                  input logic [TIME_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/order_timer_sec.sv
// Unused helper package; the one-second prescaler lives in order_timer_sec_prescaler.sv.
package order_timer_sec_dummy_pkg;
    localparam int unsigned Unused = 0;
endpackage

// File: rtl/order_timer_sec_prescaler.sv
// One-second prescaler.
//   basys_clk - system clock
//   rst_n     - asynchronous active-low reset
//   en        - count enable; the count holds its value while low
//   clr       - forces the count back to zero (has priority over en)
//   tick      - high during the cycle in which the count wraps from TICK_DIV-1 to 0
module sec_prescaler #(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic basys_clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CntW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LastCnt) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge basys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/order_timer.sv
// Round controller for the score display: counts the round down in seconds and
// latches completed orders.
//   basys_clk, rst_n   - clock, asynchronous active-low reset
//   start              - pulse, begins a new round from IDLE or DONE
//   pause              - pulse, toggles RUNNING/PAUSED
//   order_complete[2:0]- pulses, bit i marks order i delivered
//   wrong_order        - pulse, wrong dish delivered
//   time_left[15:0]    - remaining seconds
//   orders_done[2:0]   - latched completions
//   running, game_over - registered state flags
//   sec_tick           - pulses with each decrement of time_left
// Optional feature: define ORDER_TIMER_PENALTY_EN to deduct PENALTY_SEC per wrong order.
module order_timer
    import order_timer_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 100_000_000,
    parameter int unsigned START_TIME  = 180,
    parameter int unsigned PENALTY_SEC = 5
) (
    input  logic                  basys_clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  pause,
    input  logic [NUM_ORDERS-1:0] order_complete,
    input  logic                  wrong_order,
    output logic [TIME_W-1:0]     time_left,
    output logic [NUM_ORDERS-1:0] orders_done,
    output logic                  running,
    output logic                  game_over,
    output logic                  sec_tick
);

    localparam logic [TIME_W-1:0] StartVal = TIME_W'(START_TIME);

    state_e                state_q, state_d;
    logic [TIME_W-1:0]     time_q, time_d;
    logic [NUM_ORDERS-1:0] orders_q, orders_d;
    logic                  running_q, game_over_q, sec_tick_q, sec_tick_d;
    logic                  pre_en, pre_clr, pre_tick;
    logic [TIME_W-1:0]     dec;

    // A pause pulse in RUNNING only changes state; the prescaler holds on that cycle.
    assign pre_en  = (state_q == StRunning) && !pause;
    assign pre_clr = ((state_q == StIdle) || (state_q == StDone)) && start;

    sec_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .basys_clk (basys_clk),
        .rst_n     (rst_n),
        .en        (pre_en),
        .clr       (pre_clr),
        .tick      (pre_tick)
    );

`ifdef ORDER_TIMER_PENALTY_EN
    always_comb begin
        dec = pre_tick ? TIME_W'(1) : '0;
        if (wrong_order) begin
            dec = dec + TIME_W'(PENALTY_SEC);
        end
    end
`else
    assign dec = pre_tick ? TIME_W'(1) : '0;

    logic unused_penalty;
    assign unused_penalty = wrong_order | (PENALTY_SEC == 0);
`endif

    always_comb begin
        state_d    = state_q;
        time_d     = time_q;
        orders_d   = orders_q;
        sec_tick_d = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    time_d   = StartVal;
                    orders_d = '0;
                    state_d  = StRunning;
                end
            end
            StRunning: begin
                if (pause) begin
                    state_d = StPaused;
                end else begin
                    time_d     = sat_sub(time_q, dec);
                    orders_d   = orders_q | order_complete;
                    sec_tick_d = pre_tick;
                    if ((time_d == '0) || (&orders_d)) begin
                        state_d = StDone;
                    end
                end
            end
            StPaused: begin
                if (pause) begin
                    state_d = StRunning;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge basys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            time_q      <= StartVal;
            orders_q    <= '0;
            running_q   <= 1'b0;
            game_over_q <= 1'b0;
            sec_tick_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            time_q      <= time_d;
            orders_q    <= orders_d;
            running_q   <= (state_d == StRunning);
            game_over_q <= (state_d == StDone);
            sec_tick_q  <= sec_tick_d;
        end
    end

    assign time_left   = time_q;
    assign orders_done = orders_q;
    assign running     = running_q;
    assign game_over   = game_over_q;
    assign sec_tick    = sec_tick_q;

endmodule

// File: tb/tb_order_timer.sv
// Directed bench for order_timer with TICK_DIV=10, START_TIME=3, PENALTY_SEC=5.
module tb_order_timer;

    logic        basys_clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        pause;
    logic [2:0]  order_complete;
    logic        wrong_order;
    logic [15:0] time_left;
    logic [2:0]  orders_done;
    logic        running;
    logic        game_over;
    logic        sec_tick;

    int n_checks = 0;
    int n_pass   = 0;
    int n;
    int saw_tick;

    order_timer #(
        .TICK_DIV    (10),
        .START_TIME  (3),
        .PENALTY_SEC (5)
    ) dut (
        .basys_clk      (basys_clk),
        .rst_n          (rst_n),
        .start          (start),
        .pause          (pause),
        .order_complete (order_complete),
        .wrong_order    (wrong_order),
        .time_left      (time_left),
        .orders_done    (orders_done),
        .running        (running),
        .game_over      (game_over),
        .sec_tick       (sec_tick)
    );

    always #5 basys_clk = ~basys_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge basys_clk);
        @(negedge basys_clk);
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic pulse_pause();
        pause = 1'b1; step(); pause = 1'b0;
    endtask

    task automatic pulse_orders(input logic [2:0] v);
        order_complete = v; step(); order_complete = 3'b000;
    endtask

    task automatic wait_tick(output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!sec_tick && cycles < 200);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; pause = 1'b0;
        order_complete = 3'b000; wrong_order = 1'b0;
        step(); step();
        check_eq("rst_time", 32'(time_left), 3);
        check_eq("rst_orders", 32'(orders_done), 0);
        check_eq("rst_running", 32'(running), 0);
        check_eq("rst_game_over", 32'(game_over), 0);
        check_eq("rst_sec_tick", 32'(sec_tick), 0);
        rst_n = 1'b1;
        step();

        // Full countdown to zero.
        pulse_start();
        check_eq("t1_running", 32'(running), 1);
        check_eq("t1_time3", 32'(time_left), 3);
        wait_tick(n);
        check_eq("t1_tick1_cycles", 32'(n), 10);
        check_eq("t1_time2", 32'(time_left), 2);
        wait_tick(n);
        check_eq("t1_tick2_cycles", 32'(n), 10);
        check_eq("t1_time1", 32'(time_left), 1);
        wait_tick(n);
        check_eq("t1_tick3_cycles", 32'(n), 10);
        check_eq("t1_time0", 32'(time_left), 0);
        check_eq("t1_game_over", 32'(game_over), 1);
        check_eq("t1_not_running", 32'(running), 0);
        saw_tick = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (sec_tick) saw_tick = 1;
        end
        check_eq("t1_time_stays0", 32'(time_left), 0);
        check_eq("t1_no_tick_done", 32'(saw_tick), 0);

        // All orders complete ends the round with time frozen.
        pulse_start();
        check_eq("t2_restart_time", 32'(time_left), 3);
        check_eq("t2_restart_orders", 32'(orders_done), 0);
        pulse_orders(3'b001);
        check_eq("t2_orders_001", 32'(orders_done), 1);
        check_eq("t2_still_running", 32'(running), 1);
        pulse_orders(3'b110);
        check_eq("t2_orders_111", 32'(orders_done), 7);
        check_eq("t2_game_over", 32'(game_over), 1);
        check_eq("t2_time_at_done", 32'(time_left), 3);
        for (int i = 0; i < 20; i++) step();
        check_eq("t2_time_frozen", 32'(time_left), 3);

        // Pause at prescaler count 4; orders ignored while paused.
        pulse_start();
        for (int i = 0; i < 4; i++) step();
        pulse_pause();
        check_eq("t3_paused_running", 32'(running), 0);
        pulse_orders(3'b010);
        saw_tick = 0;
        for (int i = 0; i < 48; i++) begin
            step();
            if (sec_tick) saw_tick = 1;
        end
        check_eq("t3_pause_no_tick", 32'(saw_tick), 0);
        check_eq("t3_pause_time", 32'(time_left), 3);
        check_eq("t3_pause_orders", 32'(orders_done), 0);
        pulse_pause();
        check_eq("t3_resumed", 32'(running), 1);
        wait_tick(n);
        check_eq("t3_resume_cycles", 32'(n), 6);
        check_eq("t3_time2", 32'(time_left), 2);

        // Restart from DONE clears everything.
        pulse_orders(3'b111);
        check_eq("t4_done", 32'(game_over), 1);
        pulse_start();
        check_eq("t4_time", 32'(time_left), 3);
        check_eq("t4_orders", 32'(orders_done), 0);
        check_eq("t4_running", 32'(running), 1);

        // Asynchronous reset mid-round.
        wait_tick(n);
        pulse_orders(3'b011);
        check_eq("t5_pre_time", 32'(time_left), 2);
        check_eq("t5_pre_orders", 32'(orders_done), 3);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t5_rst_time", 32'(time_left), 3);
        check_eq("t5_rst_orders", 32'(orders_done), 0);
        check_eq("t5_rst_running", 32'(running), 0);
        step();
        rst_n = 1'b1;
        step();
        check_eq("t5_idle_stays", 32'(running), 0);

        // Wrong order coinciding with a tick.
        pulse_start();
        for (int i = 0; i < 9; i++) step();
        wrong_order = 1'b1; step(); wrong_order = 1'b0;
        check_eq("t6_sec_tick", 32'(sec_tick), 1);
`ifdef ORDER_TIMER_PENALTY_EN
        check_eq("t6_time", 32'(time_left), 0);
        check_eq("t6_game_over", 32'(game_over), 1);
`else
        check_eq("t6_time", 32'(time_left), 2);
        check_eq("t6_running", 32'(running), 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
